// File: rtl/exu_oitf_if.sv
// Dispatch/retire/hazard-check bundle of the outstanding long-pipe instruction tracker.
// The PC fields exist only when EXU_OITF_PC_EN is defined.
interface exu_oitf_if #(
    parameter int unsigned PTR_W       = 1,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned PC_SIZE     = 32
);
    logic                   dis_ena;
    logic                   dis_ready;
    logic                   dis_rdwen;
    logic [RFIDX_WIDTH-1:0] dis_rdidx;
    logic [PTR_W-1:0]       dis_ptr;
    logic                   ret_ena;
    logic [PTR_W-1:0]       ret_ptr;
    logic                   ret_rdwen;
    logic [RFIDX_WIDTH-1:0] ret_rdidx;
    logic                   oitf_empty;
    logic                   chk_rs1en;
    logic                   chk_rs2en;
    logic                   chk_rdwen;
    logic [RFIDX_WIDTH-1:0] chk_rs1idx;
    logic [RFIDX_WIDTH-1:0] chk_rs2idx;
    logic [RFIDX_WIDTH-1:0] chk_rdidx;
    logic                   oitfrd_match_rs1;
    logic                   oitfrd_match_rs2;
    logic                   oitfrd_match_rd;
`ifdef EXU_OITF_PC_EN
    logic [PC_SIZE-1:0]     dis_pc;
    logic [PC_SIZE-1:0]     ret_pc;
`endif

    // Dispatch / writeback side.
    modport master (
        output dis_ena, dis_rdwen, dis_rdidx, ret_ena,
        output chk_rs1en, chk_rs2en, chk_rdwen, chk_rs1idx, chk_rs2idx, chk_rdidx,
        input  dis_ready, dis_ptr, ret_ptr, ret_rdwen, ret_rdidx, oitf_empty,
        input  oitfrd_match_rs1, oitfrd_match_rs2, oitfrd_match_rd
`ifdef EXU_OITF_PC_EN
        , output dis_pc
        , input  ret_pc
`endif
    );

    // Tracker side.
    modport slave (
        input  dis_ena, dis_rdwen, dis_rdidx, ret_ena,
        input  chk_rs1en, chk_rs2en, chk_rdwen, chk_rs1idx, chk_rs2idx, chk_rdidx,
        output dis_ready, dis_ptr, ret_ptr, ret_rdwen, ret_rdidx, oitf_empty,
        output oitfrd_match_rs1, oitfrd_match_rs2, oitfrd_match_rd
`ifdef EXU_OITF_PC_EN
        , input  dis_pc
        , output ret_pc
`endif
    );
endinterface

// File: rtl/exu_oitf.sv
// Outstanding instruction track FIFO: circular queue of long-pipe rd writers with hazard checks.
// Optional per-entry PC storage is enabled by defining EXU_OITF_PC_EN.
module exu_oitf #(
    parameter int unsigned OITF_DEPTH  = 2,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned PC_SIZE     = 32
) (
    input  logic       clk,
    input  logic       rst,
    exu_oitf_if.slave  oitf
);
    localparam int unsigned PTR_W = $clog2(OITF_DEPTH);

    generate
        if ((OITF_DEPTH < 2) || (OITF_DEPTH > 16) || ((OITF_DEPTH & (OITF_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("exu_oitf: OITF_DEPTH must be a power of two in 2..16");
        end
    endgenerate

    logic [OITF_DEPTH-1:0]  vld_q;
    logic [OITF_DEPTH-1:0]  vld_d;
    logic [OITF_DEPTH-1:0]  rdwen_q;
    logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
`ifdef EXU_OITF_PC_EN
    logic [PC_SIZE-1:0]     pc_q    [OITF_DEPTH];
`endif

    // Pointers carry an extra MSB wrap bit to tell full from empty.
    logic [PTR_W:0]   alc_ptr_q;
    logic [PTR_W:0]   alc_ptr_d;
    logic [PTR_W:0]   ret_ptr_q;
    logic [PTR_W:0]   ret_ptr_d;
    logic [PTR_W-1:0] alc_idx;
    logic [PTR_W-1:0] ret_idx;
    logic             full;
    logic             empty;
    logic             alc_en;
    logic             ret_en;

    assign alc_idx = alc_ptr_q[PTR_W-1:0];
    assign ret_idx = ret_ptr_q[PTR_W-1:0];
    assign full    = (alc_idx == ret_idx) && (alc_ptr_q[PTR_W] != ret_ptr_q[PTR_W]);
    assign empty   = (alc_ptr_q == ret_ptr_q);
    assign alc_en  = oitf.dis_ena & ~full;
    assign ret_en  = oitf.ret_ena & ~empty;

    // Next-state: indices can only collide when full or empty, so both updates are independent.
    always_comb begin
        vld_d     = vld_q;
        alc_ptr_d = alc_ptr_q;
        ret_ptr_d = ret_ptr_q;
        if (ret_en) begin
            vld_d[ret_idx] = 1'b0;
            ret_ptr_d      = (PTR_W+1)'(ret_ptr_q + 1'b1);
        end
        if (alc_en) begin
            vld_d[alc_idx] = 1'b1;
            alc_ptr_d      = (PTR_W+1)'(alc_ptr_q + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            alc_ptr_q <= '0;
            ret_ptr_q <= '0;
        end else begin
            vld_q     <= vld_d;
            alc_ptr_q <= alc_ptr_d;
            ret_ptr_q <= ret_ptr_d;
        end
    end

    // Payload is unreset; every read of it is qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (alc_en) begin
            rdwen_q[alc_idx] <= oitf.dis_rdwen;
            rdidx_q[alc_idx] <= oitf.dis_rdidx;
`ifdef EXU_OITF_PC_EN
            pc_q[alc_idx]    <= oitf.dis_pc;
`endif
        end
    end

    assign oitf.dis_ready  = ~full;
    assign oitf.oitf_empty = empty;
    assign oitf.dis_ptr    = alc_idx;
    assign oitf.ret_ptr    = ret_idx;
    assign oitf.ret_rdwen  = vld_q[ret_idx] & rdwen_q[ret_idx];
    assign oitf.ret_rdidx  = vld_q[ret_idx] ? rdidx_q[ret_idx] : '0;
`ifdef EXU_OITF_PC_EN
    assign oitf.ret_pc     = vld_q[ret_idx] ? pc_q[ret_idx] : '0;
`endif

    // Hazard flags look at pre-edge entries only.
    always_comb begin
        oitf.oitfrd_match_rs1 = 1'b0;
        oitf.oitfrd_match_rs2 = 1'b0;
        oitf.oitfrd_match_rd  = 1'b0;
        for (int unsigned i = 0; i < OITF_DEPTH; i++) begin
            if (vld_q[i] && rdwen_q[i]) begin
                if (oitf.chk_rs1en && (rdidx_q[i] == oitf.chk_rs1idx)) oitf.oitfrd_match_rs1 = 1'b1;
                if (oitf.chk_rs2en && (rdidx_q[i] == oitf.chk_rs2idx)) oitf.oitfrd_match_rs2 = 1'b1;
                if (oitf.chk_rdwen && (rdidx_q[i] == oitf.chk_rdidx))  oitf.oitfrd_match_rd  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_exu_oitf.sv
// Scoreboard bench for exu_oitf: a queue of allocated entries predicts retire payloads and hazards.
module tb_exu_oitf;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned RFW   = 5;
    localparam int unsigned PCW   = 32;
    localparam int unsigned PTRW  = 1;

    typedef struct packed {
        logic           w;
        logic [RFW-1:0] idx;
        logic [PCW-1:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    ent_t sb[$];
    int   m_alc = 0;
    int   m_ret = 0;

    always #5 clk = ~clk;

    exu_oitf_if #(.PTR_W(PTRW), .RFIDX_WIDTH(RFW), .PC_SIZE(PCW)) bus ();

    exu_oitf #(.OITF_DEPTH(DEPTH), .RFIDX_WIDTH(RFW), .PC_SIZE(PCW)) dut (
        .clk  (clk),
        .rst  (rst),
        .oitf (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every observable output against the scoreboard state before the edge.
    task automatic check_state();
        logic m1, m2, md;
        m1 = 1'b0; m2 = 1'b0; md = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].w && bus.chk_rs1en && sb[i].idx == bus.chk_rs1idx) m1 = 1'b1;
            if (sb[i].w && bus.chk_rs2en && sb[i].idx == bus.chk_rs2idx) m2 = 1'b1;
            if (sb[i].w && bus.chk_rdwen && sb[i].idx == bus.chk_rdidx)  md = 1'b1;
        end
        check("dis_ready",  32'(bus.dis_ready),  32'(sb.size() != DEPTH));
        check("oitf_empty", 32'(bus.oitf_empty), 32'(sb.size() == 0));
        check("dis_ptr",    32'(bus.dis_ptr),    32'(m_alc));
        check("ret_ptr",    32'(bus.ret_ptr),    32'(m_ret));
        check("match_rs1",  32'(bus.oitfrd_match_rs1), 32'(m1));
        check("match_rs2",  32'(bus.oitfrd_match_rs2), 32'(m2));
        check("match_rd",   32'(bus.oitfrd_match_rd),  32'(md));
        if (sb.size() == 0) begin
            check("ret_rdwen_empty", 32'(bus.ret_rdwen), 32'd0);
            check("ret_rdidx_empty", 32'(bus.ret_rdidx), 32'd0);
        end
    endtask

    task automatic set_chk(input logic e1, input logic [RFW-1:0] i1, input logic e2,
                           input logic [RFW-1:0] i2, input logic ed, input logic [RFW-1:0] id);
        bus.chk_rs1en = e1; bus.chk_rs1idx = i1;
        bus.chk_rs2en = e2; bus.chk_rs2idx = i2;
        bus.chk_rdwen = ed; bus.chk_rdidx  = id;
    endtask

    // One clock: drive mid-low phase, check, update the model, cross the rising edge.
    task automatic step(input logic de, input logic dw, input logic [RFW-1:0] di,
                        input logic re, input logic [PCW-1:0] pc);
        ent_t e;
        bit   do_alc, do_ret;
        @(negedge clk);
        bus.dis_ena = de; bus.dis_rdwen = dw; bus.dis_rdidx = di; bus.ret_ena = re;
`ifdef EXU_OITF_PC_EN
        bus.dis_pc = pc;
`endif
        #1;
        check_state();
        do_alc = de && (sb.size() != DEPTH);
        do_ret = re && (sb.size() != 0);
        if (do_ret) begin
            e = sb.pop_front();
            check("ret_rdwen", 32'(bus.ret_rdwen), 32'(e.w));
            check("ret_rdidx", 32'(bus.ret_rdidx), 32'(e.idx));
`ifdef EXU_OITF_PC_EN
            check("ret_pc", bus.ret_pc, e.pc);
`endif
            m_ret = (m_ret + 1) % DEPTH;
        end
        if (do_alc) begin
            e.w = dw; e.idx = di; e.pc = pc;
            sb.push_back(e);
            m_alc = (m_alc + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
        bus.dis_ena = 1'b0;
        bus.ret_ena = 1'b0;
    endtask

    initial begin
        bus.dis_ena = 1'b0; bus.dis_rdwen = 1'b0; bus.dis_rdidx = '0; bus.ret_ena = 1'b0;
`ifdef EXU_OITF_PC_EN
        bus.dis_pc = '0;
`endif
        set_chk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset, with every check port enabled.
        set_chk(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0);
        step(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 5'd0, 1'b1, 32'h0);

        // Fill rd=5, rd=7; third allocation while full is dropped.
        set_chk(1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 5'd7);
        step(1'b1, 1'b1, 5'd5, 1'b0, 32'h8000_0004);
        step(1'b1, 1'b1, 5'd7, 1'b0, 32'h8000_0008);
        step(1'b1, 1'b1, 5'd3, 1'b0, 32'h8000_000c);
        // Full plus simultaneous retire: retire happens, allocation does not.
        step(1'b1, 1'b1, 5'd3, 1'b1, 32'h8000_0010);
        step(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);

        // Occupancy 1: simultaneous allocate rd=9 and retire.
        step(1'b1, 1'b1, 5'd9, 1'b1, 32'h8000_0014);
        set_chk(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd9);
        step(1'b0, 1'b0, 5'd0, 1'b1, 32'h0);

        // Entry that does not write rd never matches.
        step(1'b1, 1'b0, 5'd4, 1'b0, 32'h8000_0018);
        set_chk(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd4);
        step(1'b0, 1'b0, 5'd0, 1'b1, 32'h0);

        // Six alloc/retire pairs through the wrap, plus retire on empty.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 5'(10 + i), 1'b0, 32'(32'h8000_0100 + 4 * i));
            step(1'b0, 1'b0, 5'd0, 1'b1, 32'h0);
            step(1'b0, 1'b0, 5'd0, 1'b1, 32'h0);
        end

        // Random traffic with random hazard probes.
        for (int i = 0; i < 300; i++) begin
            set_chk(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                    5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)));
            step(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), $urandom);
        end

        // Fill, then asynchronous reset must empty the tracker before any clock edge.
        while (sb.size() != DEPTH) step(1'b1, 1'b1, 5'd6, 1'b0, 32'h8000_0200);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_empty",  32'(bus.oitf_empty), 32'd1);
        check("rst_ready",  32'(bus.dis_ready),  32'd1);
        check("rst_retptr", 32'(bus.ret_ptr),    32'd0);
        check("rst_disptr", 32'(bus.dis_ptr),    32'd0);
        check("rst_rdwen",  32'(bus.ret_rdwen),  32'd0);
        sb.delete();
        m_alc = 0;
        m_ret = 0;
        @(negedge clk);
        rst = 1'b0;
        set_chk(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd6);
        step(1'b0, 1'b0, 5'd0, 1'b1, 32'h0);

        // PC capture of a fresh entry.
        step(1'b1, 1'b1, 5'd1, 1'b0, 32'h8000_0004);
        step(1'b0, 1'b0, 5'd0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/exu_oitf.md
EXU_OITF -- requirements
Module: exu_oitf

Interface
REQ-001 Parameter OITF_DEPTH, default 2: number of tracked long-pipe instructions; SHALL be a power of two, 2..16.
REQ-002 Derived PTR_W = log2(OITF_DEPTH); pointers carry one extra wrap bit internally.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 dis_ena  input  1  allocate request, driven by dispatch (valid & ready & longpipe).
REQ-006 dis_ready  output  1  high when an entry is free.
REQ-007 dis_rdwen  input  1  allocated instruction writes rd.
REQ-008 dis_rdidx  input  RFIDX_WIDTH  allocated instruction rd index.
REQ-009 dis_ptr  output  PTR_W  entry index the next allocation takes.
REQ-010 ret_ena  input  1  long-pipe writeback retires the oldest entry.
REQ-011 ret_ptr  output  PTR_W  index of the oldest entry.
REQ-012 ret_rdwen / ret_rdidx  output  1 / RFIDX_WIDTH  rdwen and rdidx of the oldest entry.
REQ-013 oitf_empty  output  1  no valid entries.
REQ-014 chk_rs1en, chk_rs2en, chk_rdwen  input  1 each  operand enables of the instruction being dispatched.
REQ-015 chk_rs1idx, chk_rs2idx, chk_rdidx  input  RFIDX_WIDTH each  its operand indices.
REQ-016 oitfrd_match_rs1, oitfrd_match_rs2, oitfrd_match_rd  output  1 each  hazard flags.
REQ-017 ret_pc  output  PC_SIZE  PC of the oldest entry, present only under EXU_OITF_PC_EN.
REQ-018 dis_pc  input  PC_SIZE  PC of the allocated instruction, present only under EXU_OITF_PC_EN.

Function
REQ-019 The block SHALL be a circular FIFO of OITF_DEPTH entries, each holding valid, rdwen and rdidx.
REQ-020 Allocation: when dis_ena & dis_ready, the entry at the allocate pointer SHALL capture dis_rdwen/dis_rdidx, be marked valid, and the allocate pointer SHALL increment, next cycle.
REQ-021 Retire: when ret_ena & ~oitf_empty, the entry at the retire pointer SHALL be cleared and the retire pointer SHALL increment, next cycle.
REQ-022 Pointers SHALL wrap from OITF_DEPTH-1 to 0 and toggle their wrap bit.
REQ-023 Full = (index bits equal) & (wrap bits differ); empty = both equal; dis_ready = ~full; oitf_empty = empty.
REQ-024 dis_ready SHALL depend only on registered state; a same-cycle retire SHALL NOT make a full FIFO accept an allocation.
REQ-025 dis_ena while full SHALL be ignored, with no state change.
REQ-026 ret_ena while empty SHALL be ignored, with no state change.
REQ-027 Simultaneous allocation and retire when neither full nor empty SHALL both take effect; occupancy is unchanged.
REQ-028 oitfrd_match_rs1 = OR over valid entries of (rdwen & rdidx==chk_rs1idx & chk_rs1en); rs2 is analogous.
REQ-029 oitfrd_match_rd = OR over valid entries of (rdwen & rdidx==chk_rdidx & chk_rdwen).
REQ-030 Match outputs SHALL be combinational from current registered entries; an entry retiring or allocating this cycle counts as its pre-edge state.
REQ-031 ret_rdwen/ret_rdidx/ret_pc SHALL be combinational reads of the retire-pointer entry, and SHALL read 0 when empty.

Reset
REQ-032 On rst all valid bits, pointers and wrap bits SHALL clear immediately, independent of clk.
REQ-033 After reset: dis_ready=1, oitf_empty=1, dis_ptr=0, ret_ptr=0, all match flags 0, ret_rdwen=0, ret_rdidx=0.
REQ-034 rst asserted mid-operation SHALL discard all outstanding entries; no retire is reported for them.
REQ-035 Entry payload fields need not be reset; they SHALL be masked by valid.

Configuration
REQ-036 Macro EXU_OITF_PC_EN: when defined, each entry SHALL store dis_pc at allocation, and ret_pc SHALL present the oldest entry's PC.
REQ-037 Without EXU_OITF_PC_EN, the dis_pc and ret_pc ports and the PC storage SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 Reset then idle -> dis_ready=1, oitf_empty=1, ptrs 0, all matches 0.
REQ-039 DEPTH=2: allocate rd=5, then rd=7 on consecutive cycles -> dis_ready=0 after the second; a third dis_ena is ignored; ret_rdidx=5.
REQ-040 Entry rd=5 valid; chk_rs1en=1, rs1idx=5 -> match_rs1=1; chk_rs2idx=5 with chk_rs2en=0 -> match_rs2=0; after retire -> match_rs1=0.
REQ-041 Occupancy 1, simultaneous dis_ena(rd=9) and ret_ena -> occupancy stays 1, ret_rdidx=9, both ptrs advance by 1.
REQ-042 Six alloc/retire pairs at DEPTH=2 -> pointers wrap, full/empty correct at every step; ret_ena when empty has no effect.
REQ-043 Assert rst with 2 entries valid -> oitf_empty=1 before the next clk edge; with EXU_OITF_PC_EN, alloc pc=0x80000004 -> ret_pc=0x80000004.
